// File: rtl/id_exe_pipe_reg.sv
// rtl/id_exe_pipe_reg.sv - ID->EX pipeline register with stall handshake, flush and operand forwarding
// Optional feature macro: ID_EXE_PERF_CNT_EN (stall/bubble performance counters)
module id_exe_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int AW      = 6,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic                    ex_ready,
  output logic                    ex_valid,
  input  logic                    flush,
  input  logic [XLEN-1:0]         pc_id,
  input  logic [XLEN-1:0]         imm_id,
  input  logic [CTRL_W-1:0]       ctrl_id,
  input  logic [AW-1:0]           rd_id,
  input  logic [AW-1:0]           rs1_id,
  input  logic [AW-1:0]           rs2_id,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [XLEN-1:0]         frs1_data,
  input  logic [XLEN-1:0]         frs2_data,
  input  logic [NUM_FWD-1:0]      fwd_vld,
  input  logic [NUM_FWD*AW-1:0]   fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]         pc_ex,
  output logic [XLEN-1:0]         imm_ex,
  output logic [CTRL_W-1:0]       ctrl_ex,
  output logic [AW-1:0]           rd_ex,
  output logic [AW-1:0]           rs1_ex,
  output logic [AW-1:0]           rs2_ex,
  output logic [XLEN-1:0]         op1_ex,
  output logic [XLEN-1:0]         op2_ex,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             bubble_cnt
);

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_pc, r_imm, r_op1, r_op2;
  logic [CTRL_W-1:0] r_ctrl;
  logic [AW-1:0]     r_rd, r_rs1, r_rs2;

  logic              w_id_ready;
  logic              w_id1_hit, w_id2_hit, w_ex1_hit, w_ex2_hit;
  logic [XLEN-1:0]   w_id1_fwd, w_id2_fwd, w_ex1_fwd, w_ex2_fwd;
  logic [XLEN-1:0]   w_op1_id, w_op2_id;

  // Returns {hit, data}; scanning from the oldest source down lets the youngest (index 0) win.
  // Integer x0 never matches; FP f0 has bit AW-1 set so it is nonzero and forwards normally.
  function automatic logic [XLEN:0] f_lookup(
    input logic [AW-1:0]           a,
    input logic [NUM_FWD-1:0]      v,
    input logic [NUM_FWD*AW-1:0]   fa,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (v[k] && (fa[k*AW +: AW] == a) && (a != '0)) begin
        res = {1'b1, fd[k*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  assign w_id_ready = !r_ex_valid || ex_ready;

  // Forwarding lookups for the incoming (load) and held (stall refresh) source addresses
  always_comb begin
    {w_id1_hit, w_id1_fwd} = f_lookup(rs1_id, fwd_vld, fwd_addr, fwd_data);
    {w_id2_hit, w_id2_fwd} = f_lookup(rs2_id, fwd_vld, fwd_addr, fwd_data);
    {w_ex1_hit, w_ex1_fwd} = f_lookup(r_rs1, fwd_vld, fwd_addr, fwd_data);
    {w_ex2_hit, w_ex2_fwd} = f_lookup(r_rs2, fwd_vld, fwd_addr, fwd_data);
    w_op1_id = w_id1_hit ? w_id1_fwd : (rs1_id[AW-1] ? frs1_data : rs1_data);
    w_op2_id = w_id2_hit ? w_id2_fwd : (rs2_id[AW-1] ? frs2_data : rs2_data);
  end

  // Stage register: reset > flush > load > hold-with-forwarding-refresh
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_id_ready) begin
      r_ex_valid <= id_valid;
      r_pc       <= pc_id;
      r_imm      <= imm_id;
      r_ctrl     <= ctrl_id;
      r_rd       <= rd_id;
      r_rs1      <= rs1_id;
      r_rs2      <= rs2_id;
      r_op1      <= w_op1_id;
      r_op2      <= w_op2_id;
    end else begin
      if (w_ex1_hit) r_op1 <= w_ex1_fwd;
      if (w_ex2_hit) r_op2 <= w_ex2_fwd;
    end
  end

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;

  // Saturating stall / bubble counters observing the currently held state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_ex_valid && !ex_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!r_ex_valid && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

  assign id_ready = w_id_ready;
  assign ex_valid = r_ex_valid;
  assign pc_ex    = r_pc;
  assign imm_ex   = r_imm;
  assign ctrl_ex  = r_ctrl;
  assign rd_ex    = r_rd;
  assign rs1_ex   = r_rs1;
  assign rs2_ex   = r_rs2;
  assign op1_ex   = r_op1;
  assign op2_ex   = r_op2;

endmodule
